// File: rtl/sha256_mem_responder.sv
// sha256_mem_responder: word memory shared between a host load/readback
// stream and a SHA-256 engine. The host loads a message, the engine is started
// and owns the memory until done, then the 8-word digest is streamed back.
// Optional build macro SHA_MEM_ADDR_CHECK_EN adds a sticky addr_err output and
// range-checks engine accesses instead of wrapping them modulo DEPTH.
module sha256_mem_responder #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter logic [15:0] MSG_BASE     = 16'h0000,
    parameter logic [15:0] OUT_BASE     = 16'h0020
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        host_in_valid,
    output logic        host_in_ready,
    input  logic [31:0] host_in_data,

    output logic        host_out_valid,
    input  logic        host_out_ready,
    output logic [31:0] host_out_data,

    output logic        busy,

    output logic        eng_start,
    input  logic        eng_done,
    output logic [15:0] eng_message_addr,
    output logic [15:0] eng_output_addr,

    input  logic [15:0] eng_mem_addr,
    input  logic        eng_mem_we,
    input  logic [31:0] eng_mem_write_data,
    output logic [31:0] eng_mem_read_data
`ifdef SHA_MEM_ADDR_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW        = (NUM_OF_WORDS > 1) ? $clog2(NUM_OF_WORDS) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(NUM_OF_WORDS - 1);
    localparam logic [2:0]    LAST_OUT  = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        DRAIN     = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] load_cnt;
    logic [2:0]    out_cnt;
    logic [31:0]   mem [DEPTH];

    logic          in_beat;
    logic          eng_window;
    logic          eng_in_range;
    logic          eng_wr_ok;
    logic [AW-1:0] msg_idx;
    logic [AW-1:0] out_idx_cur;
    logic [AW-1:0] out_idx_nxt;
    logic [AW-1:0] eng_idx;

    // Fixed job addresses handed to the engine
    assign eng_message_addr = MSG_BASE;
    assign eng_output_addr  = OUT_BASE;

    // Address arithmetic truncates to AW bits, giving modulo-DEPTH wrap
    assign in_beat     = host_in_valid & host_in_ready;
    assign msg_idx     = AW'(MSG_BASE) + AW'(load_cnt);
    assign out_idx_cur = AW'(OUT_BASE) + AW'(out_cnt);
    assign out_idx_nxt = AW'(OUT_BASE) + AW'(out_cnt) + AW'(1);
    assign eng_idx     = eng_mem_addr[AW-1:0];
    assign eng_window  = (state == WAIT_BUSY) || (state == WAIT_DONE);

`ifdef SHA_MEM_ADDR_CHECK_EN
    assign eng_in_range = (32'(eng_mem_addr) < DEPTH);
`else
    assign eng_in_range = 1'b1;
    logic unused_addr_bits;
    assign unused_addr_bits = ^eng_mem_addr;
`endif

    assign eng_wr_ok = eng_window & eng_mem_we & eng_in_range;

    // Storage array: host writes while loading, engine writes while it owns memory
    always_ff @(posedge clk) begin
        if (in_beat) begin
            mem[msg_idx] <= host_in_data;
        end else if (eng_wr_ok) begin
            mem[eng_idx] <= eng_mem_write_data;
        end
    end

    // Engine read port: one-cycle latency in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_mem_read_data <= '0;
        end else if (eng_in_range) begin
            eng_mem_read_data <= mem[eng_idx];
        end else begin
            eng_mem_read_data <= '0;
        end
    end

`ifdef SHA_MEM_ADDR_CHECK_EN
    // Sticky flag: any engine write, or any access while the engine owns memory, out of range
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_err <= 1'b0;
        end else if (!eng_in_range && (eng_mem_we || eng_window)) begin
            addr_err <= 1'b1;
        end
    end
`endif

    // Job sequencer with registered handshake and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            load_cnt       <= '0;
            out_cnt        <= '0;
            host_in_ready  <= 1'b1;
            eng_start      <= 1'b0;
            host_out_valid <= 1'b0;
            host_out_data  <= '0;
            busy           <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (in_beat) begin
                        busy <= 1'b1;
                        if (load_cnt == LAST_WORD) begin
                            state         <= START;
                            load_cnt      <= '0;
                            host_in_ready <= 1'b0;
                            eng_start     <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            load_cnt <= load_cnt + CW'(1);
                        end
                    end
                end
                START: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // done may still be high from the previous job; wait for it to drop
                    if (!eng_done) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (eng_done) begin
                        state   <= DRAIN;
                        out_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (!host_out_valid) begin
                        host_out_valid <= 1'b1;
                        host_out_data  <= mem[out_idx_cur];
                    end else if (host_out_ready) begin
                        if (out_cnt == LAST_OUT) begin
                            host_out_valid <= 1'b0;
                            out_cnt        <= '0;
                            state          <= IDLE;
                            busy           <= 1'b0;
                            host_in_ready  <= 1'b1;
                        end else begin
                            out_cnt       <= out_cnt + 3'd1;
                            host_out_data <= mem[out_idx_nxt];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
